// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status from the datapath toward the
// hazard controller, and stall/flush/forward controls plus performance
// counters back to the datapath.
interface hazard_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              RegWriteM;
  logic              RegWriteW;
  logic [ADDR_W-1:0] RD_M;
  logic [ADDR_W-1:0] RD_W;
  logic [ADDR_W-1:0] RD_E;
  logic [ADDR_W-1:0] Rs1_E;
  logic [ADDR_W-1:0] Rs2_E;
  logic [ADDR_W-1:0] Rs1_D;
  logic [ADDR_W-1:0] Rs2_D;
  logic              ResultSrcE0;
  logic              PCSrcE;
  logic              MdStartE;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              StallF;
  logic              StallD;
  logic              StallE;
  logic              FlushD;
  logic              FlushE;
  logic              FlushM;
  logic              MdBusy;
  logic [CNT_W-1:0]  LwStallCnt;
  logic [CNT_W-1:0]  MdStallCnt;
  logic [CNT_W-1:0]  FlushCnt;

  // Datapath side: reports pipeline contents, receives hazard controls.
  modport master (
    output RegWriteM, RegWriteW, RD_M, RD_W, RD_E, Rs1_E, Rs2_E,
           Rs1_D, Rs2_D, ResultSrcE0, PCSrcE, MdStartE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
           FlushD, FlushE, FlushM, MdBusy, LwStallCnt, MdStallCnt, FlushCnt
  );

  // Controller side: observes pipeline contents, drives hazard controls.
  modport slave (
    input  RegWriteM, RegWriteW, RD_M, RD_W, RD_E, Rs1_E, Rs2_E,
           Rs1_D, Rs2_D, ResultSrcE0, PCSrcE, MdStartE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
           FlushD, FlushE, FlushM, MdBusy, LwStallCnt, MdStallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RISC-V pipeline: M/W->E forwarding,
// load-use bubbles, branch flushes and a busy FSM that holds multi-cycle
// MUL/DIV ops in E for MD_LAT cycles.
// Optional performance counters are enabled by defining HAZARD_PERF_EN;
// without it the counter outputs are tied to zero.
module hazard_ctrl #(
  parameter int ADDR_W = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave h
);

  localparam logic [ADDR_W-1:0] REG_ZERO    = '0;
  localparam bit                MD_MULTI    = (MD_LAT > 1);
  localparam logic [7:0]        MD_CNT_INIT = 8'(MD_LAT - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       md_busy;
  logic       md_stall;
  logic       lw_stall;
  logic       m_hit_a;
  logic       w_hit_a;
  logic       m_hit_b;
  logic       w_hit_b;

  // Forwarding selects: M has the younger result so it wins over W; x0 never forwards.
  always_comb begin
    m_hit_a = h.RegWriteM && (h.RD_M != REG_ZERO) && (h.RD_M == h.Rs1_E);
    w_hit_a = h.RegWriteW && (h.RD_W != REG_ZERO) && (h.RD_W == h.Rs1_E);
    m_hit_b = h.RegWriteM && (h.RD_M != REG_ZERO) && (h.RD_M == h.Rs2_E);
    w_hit_b = h.RegWriteW && (h.RD_W != REG_ZERO) && (h.RD_W == h.Rs2_E);
    h.ForwardAE = m_hit_a ? 2'b10 : (w_hit_a ? 2'b01 : 2'b00);
    h.ForwardBE = m_hit_b ? 2'b10 : (w_hit_b ? 2'b01 : 2'b00);
  end

  // Stall/flush decode; a taken branch kills the D instruction so it cannot cause a load-use stall.
  always_comb begin
    lw_stall = h.ResultSrcE0 && (h.RD_E != REG_ZERO) &&
               ((h.RD_E == h.Rs1_D) || (h.RD_E == h.Rs2_D)) && !h.PCSrcE;
    if (state == BUSY) begin
      md_stall = (cnt > 8'd1);
    end else begin
      md_stall = h.MdStartE && MD_MULTI;
    end
    h.StallF = lw_stall | md_stall;
    h.StallD = lw_stall | md_stall;
    h.StallE = md_stall;
    h.FlushD = h.PCSrcE;
    h.FlushE = lw_stall | h.PCSrcE;
    h.FlushM = md_stall;
    h.MdBusy = md_busy;
  end

  // Multi-cycle op sequencer: counts down the remaining E cycles, returns to IDLE on the last one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      md_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (h.MdStartE && MD_MULTI) begin
            state   <= BUSY;
            cnt     <= MD_CNT_INIT;
            md_busy <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt <= 8'd1) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            md_busy <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= 8'd0;
          md_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] lw_cnt;
  logic [CNT_W-1:0] md_cnt;
  logic [CNT_W-1:0] fl_cnt;

  // Saturating event counters for load-use stalls, MD stalls and branch flushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lw_cnt <= '0;
      md_cnt <= '0;
      fl_cnt <= '0;
    end else begin
      if (lw_stall && (lw_cnt != CNT_MAX)) lw_cnt <= lw_cnt + CNT_ONE;
      if (md_stall && (md_cnt != CNT_MAX)) md_cnt <= md_cnt + CNT_ONE;
      if (h.PCSrcE && (fl_cnt != CNT_MAX)) fl_cnt <= fl_cnt + CNT_ONE;
    end
  end

  assign h.LwStallCnt = lw_cnt;
  assign h.MdStallCnt = md_cnt;
  assign h.FlushCnt   = fl_cnt;
`else
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  assign h.LwStallCnt = CNT_ZERO;
  assign h.MdStallCnt = CNT_ZERO;
  assign h.FlushCnt   = CNT_ZERO;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (MD_LAT=4, CNT_W=16).
// Control outputs are compared as a packed vector
// {StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy}.
module tb_hazard_ctrl;

  logic clk;
  logic rst;
  int   checkCount;
  int   failCount;

  hazard_ctrl_if #(.ADDR_W(5), .CNT_W(16)) hif ();

  hazard_ctrl #(.ADDR_W(5), .MD_LAT(4), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .h   (hif.slave)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 unit later.
  task automatic applyStimulus(input logic rwm, input logic rww,
                               input logic [4:0] rdm, input logic [4:0] rdw,
                               input logic [4:0] rde, input logic [4:0] rs1e,
                               input logic [4:0] rs2e, input logic [4:0] rs1d,
                               input logic [4:0] rs2d, input logic ld,
                               input logic pcs, input logic mds);
    @(negedge clk);
    hif.RegWriteM   = rwm;
    hif.RegWriteW   = rww;
    hif.RD_M        = rdm;
    hif.RD_W        = rdw;
    hif.RD_E        = rde;
    hif.Rs1_E       = rs1e;
    hif.Rs2_E       = rs2e;
    hif.Rs1_D       = rs1d;
    hif.Rs2_D       = rs2d;
    hif.ResultSrcE0 = ld;
    hif.PCSrcE      = pcs;
    hif.MdStartE    = mds;
    #1;
  endtask

  function automatic logic [6:0] ctrlVec();
    return {hif.StallF, hif.StallD, hif.StallE, hif.FlushD, hif.FlushE,
            hif.FlushM, hif.MdBusy};
  endfunction

  function automatic logic [3:0] fwdVec();
    return {hif.ForwardAE, hif.ForwardBE};
  endfunction

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [6:0] mdExp [4];

  initial begin
    checkCount = 0;
    failCount  = 0;
    mdExp[0] = 7'b1110010;
    mdExp[1] = 7'b1110011;
    mdExp[2] = 7'b1110011;
    mdExp[3] = 7'b0000001;

    rst             = 1'b0;
    hif.RegWriteM   = 1'b0;
    hif.RegWriteW   = 1'b0;
    hif.RD_M        = '0;
    hif.RD_W        = '0;
    hif.RD_E        = '0;
    hif.Rs1_E       = '0;
    hif.Rs2_E       = '0;
    hif.Rs1_D       = '0;
    hif.Rs2_D       = '0;
    hif.ResultSrcE0 = 1'b0;
    hif.PCSrcE      = 1'b0;
    hif.MdStartE    = 1'b0;
    #2;
    $display("[TB] reset state");
    checkOutput("rst_ctrl", 32'(ctrlVec()), 32'h0);
    checkOutput("rst_fwd", 32'(fwdVec()), 32'h0);
    checkOutput("rst_cnt", 32'(hif.LwStallCnt | hif.MdStallCnt | hif.FlushCnt), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] forwarding");
    applyStimulus(1, 1, 5, 5, 0, 5, 0, 0, 0, 0, 0, 0);
    checkOutput("fwd_m_wins", 32'(fwdVec()), 32'b1000);
    checkOutput("fwd_ctrl_idle", 32'(ctrlVec()), 32'h0);
    applyStimulus(0, 1, 5, 5, 0, 5, 0, 0, 0, 0, 0, 0);
    checkOutput("fwd_w_only", 32'(fwdVec()), 32'b0100);
    applyStimulus(1, 1, 0, 3, 0, 3, 3, 0, 0, 0, 0, 0);
    checkOutput("fwd_w_both", 32'(fwdVec()), 32'b0101);
    applyStimulus(1, 1, 6, 3, 0, 3, 6, 0, 0, 0, 0, 0);
    checkOutput("fwd_split", 32'(fwdVec()), 32'b0110);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("fwd_x0", 32'(fwdVec()), 32'b0000);

    $display("[TB] load-use and branch flush");
    applyStimulus(0, 0, 0, 0, 7, 0, 0, 0, 7, 1, 0, 0);
    checkOutput("lw_rs2", 32'(ctrlVec()), 32'b1100100);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0);
    checkOutput("lw_release", 32'(ctrlVec()), 32'b0000000);
    applyStimulus(0, 0, 0, 0, 9, 0, 0, 9, 2, 1, 0, 0);
    checkOutput("lw_rs1", 32'(ctrlVec()), 32'b1100100);
    applyStimulus(0, 0, 0, 0, 7, 0, 0, 0, 7, 1, 1, 0);
    checkOutput("lw_branch", 32'(ctrlVec()), 32'b0001100);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("lw_x0", 32'(ctrlVec()), 32'b0000000);
    applyStimulus(0, 0, 0, 0, 7, 0, 0, 0, 8, 1, 0, 0);
    checkOutput("lw_nomatch", 32'(ctrlVec()), 32'b0000000);

    $display("[TB] single MD op");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 9, 0, 0, 9, 0, 0, 0, 0, 1);
      checkOutput($sformatf("md1_c%0d", i), 32'(ctrlVec()), 32'(mdExp[i]));
      if (i == 2) checkOutput("md_fwd_live", 32'(fwdVec()), 32'b0001);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("md1_idle", 32'(ctrlVec()), 32'b0000000);

    $display("[TB] back-to-back MD ops");
    pulseReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput($sformatf("md2_c%0d", i), 32'(ctrlVec()), 32'(mdExp[i % 4]));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("md2_idle", 32'(ctrlVec()), 32'b0000000);
`ifdef HAZARD_PERF_EN
    checkOutput("md_cnt", 32'(hif.MdStallCnt), 32'd6);
`else
    checkOutput("md_cnt", 32'(hif.MdStallCnt), 32'd0);
`endif
    checkOutput("lw_cnt_zero", 32'(hif.LwStallCnt), 32'd0);

    $display("[TB] flush and load-use counting");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 4, 0, 0, 4, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_PERF_EN
    checkOutput("flush_cnt", 32'(hif.FlushCnt), 32'd3);
    checkOutput("lw_cnt", 32'(hif.LwStallCnt), 32'd2);
`else
    checkOutput("flush_cnt", 32'(hif.FlushCnt), 32'd0);
    checkOutput("lw_cnt", 32'(hif.LwStallCnt), 32'd0);
`endif

    $display("[TB] reset during BUSY");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("busy_cnt2", 32'(ctrlVec()), 32'b1110011);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_ctrl", 32'(ctrlVec()), 32'b0000000);
    checkOutput("async_rst_cnt", 32'(hif.LwStallCnt | hif.MdStallCnt | hif.FlushCnt), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput($sformatf("md3_c%0d", i), 32'(ctrlVec()), 32'(mdExp[i]));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("md3_idle", 32'(ctrlVec()), 32'b0000000);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller for the 5-stage RISC-V pipeline: it replaces pure forwarding control with full hazard resolution. It generates M/W→E forwarding selects, detects load-use hazards and inserts bubbles, flushes on taken branches/jumps, and sequences multi-cycle execute operations (MUL/DIV) with an internal busy FSM. It sits beside the datapath and drives the stall/flush enables of the F/D, D/E and E/M pipeline registers.

## Interface
- `ADDR_W`, 5: register-address width; register 0 is never forwarded or hazard-checked.
- `MD_LAT`, 4: total cycles a multi-cycle op occupies E (1..255; 1 means no stall).
- `CNT_W`, 16: width of each performance counter.

- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `RegWriteM` / `RegWriteW` in 1: register write enable in M / W.
- `RD_M` / `RD_W` / `RD_E` in ADDR_W: destination in M / W / E.
- `Rs1_E` / `Rs2_E` in ADDR_W: sources in E.
- `Rs1_D` / `Rs2_D` in ADDR_W: sources in D.
- `ResultSrcE0` in 1: instruction in E is a load.
- `PCSrcE` in 1: taken branch/jump resolved in E.
- `MdStartE` in 1: instruction in E is a multi-cycle op.
- `ForwardAE` / `ForwardBE` out 2: 00 register file, 01 from W, 10 from M.
- `StallF` / `StallD` / `StallE` out 1: hold PC / F-D / D-E registers.
- `FlushD` / `FlushE` / `FlushM` out 1: bubble into F-D / D-E / E-M.
- `MdBusy` out 1: FSM in BUSY.
- `LwStallCnt` / `MdStallCnt` / `FlushCnt` out CNT_W: performance counters.

## Operation
- Forwarding, per source (A uses Rs1_E, B uses Rs2_E): 10 if RegWriteM && RD_M!=0 && RD_M==src; otherwise 01 if RegWriteW && RD_W!=0 && RD_W==src; otherwise 00. M beats W. Forwarding is live in every cycle, stalled ones included.
- lwStall = ResultSrcE0 && RD_E!=0 && (RD_E==Rs1_D || RD_E==Rs2_D) && !PCSrcE.
- mdStall comes from the FSM:
  - IDLE: MdStartE && MD_LAT>1 → mdStall=1, cnt←MD_LAT-1, go to BUSY.
  - BUSY: mdStall = (cnt>1). cnt decrements each cycle. At cnt==1, mdStall=0, next state IDLE. MdStartE is ignored in BUSY.
- Outputs:
  - StallF = StallD = lwStall | mdStall.
  - StallE = mdStall.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
  - FlushM = mdStall.
- Priority: PCSrcE suppresses lwStall, because the D instruction is discarded anyway. While mdStall=1, E holds the MD op, so lwStall and PCSrcE are both 0 by construction.
- All 1-bit outputs are combinational. The FSM and counters are registered.

## Timing
- Reset asserted, asynchronously and including mid-operation: state IDLE, cnt=0, MdBusy=0, counters=0.
  - Combinational outputs follow their inputs. With all inputs 0, every output is 0.
- Forwarding, stall and flush outputs have zero latency from their inputs.
- An MD op issued at cycle c0 occupies E for cycles c0..c0+MD_LAT-1.
  - Stall is high for c0..c0+MD_LAT-2.
  - It leaves E at the edge ending c0+MD_LAT-1.
  - MdBusy is high c0+1..c0+MD_LAT-1.
- Back-to-back MD ops: the second reaches E at c0+MD_LAT, the FSM is IDLE, and it restarts immediately (no dead cycle).
- Load-use inserts exactly one bubble. lwStall drops the next cycle, when the load has moved to M and RD_E changes.

## Configuration
- `HAZARD_PERF_EN` defined:
  - LwStallCnt increments on cycles with lwStall.
  - MdStallCnt increments on cycles with mdStall.
  - FlushCnt increments on cycles with PCSrcE.
  - Each counter saturates at 2^CNT_W-1 and never wraps.
- `HAZARD_PERF_EN` undefined: the three counter outputs are constant 0 and no counter flops are synthesised.

## Test plan
- RD_M=RD_W=5, RegWriteM=RegWriteW=1, Rs1_E=5, Rs2_E=0 → ForwardAE=10, ForwardBE=00. Then RegWriteM=0 → ForwardAE=01.
- ResultSrcE0=1, RD_E=7, Rs2_D=7, PCSrcE=0 → StallF=StallD=FlushE=1 for 1 cycle. Same with PCSrcE=1 → StallF=StallD=0, FlushD=FlushE=1.
- MD_LAT=4, MdStartE held high 4 cycles → StallE/FlushM = 1,1,1,0; MdBusy = 0,1,1,1; then IDLE.
- Two MD ops back-to-back (MdStartE high 8 cycles, MD_LAT=4) → stall pattern 1,1,1,0,1,1,1,0. With HAZARD_PERF_EN, MdStallCnt=6.
- rst low during BUSY with cnt=2 → MdBusy=0 and StallE=0 immediately (MdStartE=0). After release, the next MdStartE starts a full MD_LAT sequence.
- With HAZARD_PERF_EN and CNT_W=2, PCSrcE high 6 cycles → FlushCnt=3 (saturated).
